reduce_fw_sequencer: RTL and testbench

- Reconfigures the per-chain firmware bytes of the vector scalar reduce stage without corrupting frames.
- Software fills a shadow table, then issues a commit. The block then:
  - waits for the upstream datapath to go quiet;
  - drops `tracing`;
  - streams the table onto the shared `configId`/`configData` bus;
  - restores `tracing`.
- Sits between the host config interface and the `tracing`/`configId`/`configData` inputs of one or more reduce units.

---
 rtl/reduce_fw_sequencer_pkg.sv | 21 ++
 rtl/reduce_fw_sequencer_if.sv | 38 +++
 rtl/reduce_fw_sequencer_drain_detector.sv | 45 ++++
 rtl/reduce_fw_sequencer.sv | 149 ++++++++++++++
 tb/tb_reduce_fw_sequencer.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/reduce_fw_sequencer_pkg.sv
// Shared types and constants for the reduce-stage firmware sequencer.
// The optional drain timeout is enabled with REDUCE_FW_SEQ_TIMEOUT_EN.
package reduce_fw_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DRAIN,
      ST_PRIME,
      ST_STREAM,
      ST_RESUME
   } fw_state_e;

   localparam logic [7:0] FW_PASSTHROUGH         = 8'd0;
   localparam logic [7:0] FW_SUM                 = 8'd1;
   localparam logic [7:0] DEFAULT_IDLE_CONFIG_ID = 8'hFF;

   function automatic int addr_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/reduce_fw_sequencer_if.sv
// Host-side and reduce-unit-side signals of the firmware sequencer, plus the
// FSM state exposed for observation. Macro REDUCE_FW_SEQ_TIMEOUT_EN affects error.
interface reduce_fw_sequencer_if
   import reduce_fw_pkg::*;
#(
   parameter int MAX_CHAINS = 4
);
   localparam int ADDR_W = addr_width(MAX_CHAINS);

   // Commit handshake: a commit is taken on any clock edge where commit_valid
   // and commit_ready are both high; commit_target must be stable while
   // commit_valid is high, and commit_ready never depends on commit_valid.
   logic              tbl_we;
   logic [ADDR_W-1:0] tbl_addr;
   logic [7:0]        tbl_data;
   logic              commit_valid;
   logic [7:0]        commit_target;
   logic              commit_ready;
   logic              upstream_valid;
   logic              tracing;
   logic [7:0]        configId;
   logic [7:0]        configData;
   logic              busy;
   logic              done;
   logic              error;
   fw_state_e         state;

   modport master (
      output tbl_we, tbl_addr, tbl_data, commit_valid, commit_target, upstream_valid,
      input  commit_ready, tracing, configId, configData, busy, done, error, state
   );

   modport slave (
      input  tbl_we, tbl_addr, tbl_data, commit_valid, commit_target, upstream_valid,
      output commit_ready, tracing, configId, configData, busy, done, error, state
   );

endinterface

// File: rtl/reduce_fw_sequencer_drain_detector.sv
// Quiet-window counter for upstream drain, plus the drain timeout timer that
// exists only when REDUCE_FW_SEQ_TIMEOUT_EN is defined.
module drain_detector #(
   parameter int DRAIN_CYCLES = 4
`ifdef REDUCE_FW_SEQ_TIMEOUT_EN
   ,
   parameter int TIMEOUT_CYCLES = 1024
`endif
) (
   input  logic clk,
   input  logic rst,
   input  logic enable,
   input  logic upstream_valid,
   output logic quiet,
   output logic timeout
);

   localparam int QW = $clog2(DRAIN_CYCLES + 1);

   logic [QW-1:0] quiet_cnt;

   always_ff @(posedge clk) begin
      if (rst || !enable || upstream_valid) quiet_cnt <= '0;
      else                                  quiet_cnt <= quiet_cnt + QW'(1);
   end

   // quiet fires on the D-th consecutive idle cycle, so the caller leaves next edge
   assign quiet = enable && !upstream_valid && (quiet_cnt == QW'(DRAIN_CYCLES - 1));

`ifdef REDUCE_FW_SEQ_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   logic [TW-1:0] timer;

   always_ff @(posedge clk) begin
      if (rst || !enable) timer <= '0;
      else                timer <= timer + TW'(1);
   end

   assign timeout = enable && (timer == TW'(TIMEOUT_CYCLES - 1));
`else
   assign timeout = 1'b0;
`endif

endmodule

// File: rtl/reduce_fw_sequencer.sv
// Commits a shadow firmware table to one reduce unit: drain upstream, drop
// tracing, stream the snapshot on configId/configData, restore tracing.
// Optional drain timeout: REDUCE_FW_SEQ_TIMEOUT_EN.
module reduce_fw_sequencer
   import reduce_fw_pkg::*;
#(
   parameter int         MAX_CHAINS     = 4,
   parameter int         DRAIN_CYCLES   = 4,
   parameter logic [7:0] IDLE_CONFIG_ID = DEFAULT_IDLE_CONFIG_ID,
   parameter int         TIMEOUT_CYCLES = 1024
) (
   input logic                 clk,
   input logic                 rst,
   reduce_fw_sequencer_if.slave bus
);

   localparam int ADDR_W = addr_width(MAX_CHAINS);

   logic [7:0]        tbl  [MAX_CHAINS];
   logic [7:0]        snap [MAX_CHAINS];
   logic [7:0]        target_q;
   fw_state_e         state_q, state_d;
   logic [ADDR_W-1:0] k_q, k_d;
   logic              quiet, timeout, accept;
   logic              tracing_d, done_d, busy_d, error_d;
   logic [7:0]        config_id_d, config_data_d;

   assign bus.commit_ready = (state_q == ST_IDLE) && !rst;
   assign accept           = bus.commit_valid && bus.commit_ready;
   assign bus.state        = state_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < MAX_CHAINS; i++) tbl[i] <= FW_PASSTHROUGH;
      end else if (bus.tbl_we) begin
         tbl[bus.tbl_addr] <= bus.tbl_data;
      end
   end

   // A write landing in the acceptance cycle is forwarded into the snapshot.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < MAX_CHAINS; i++) snap[i] <= FW_PASSTHROUGH;
         target_q <= IDLE_CONFIG_ID;
      end else if (accept) begin
         for (int i = 0; i < MAX_CHAINS; i++)
            snap[i] <= (bus.tbl_we && bus.tbl_addr == ADDR_W'(i)) ? bus.tbl_data : tbl[i];
         target_q <= bus.commit_target;
      end
   end

   drain_detector #(
      .DRAIN_CYCLES   (DRAIN_CYCLES)
`ifdef REDUCE_FW_SEQ_TIMEOUT_EN
      ,
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
`endif
   ) u_drain (
      .clk            (clk),
      .rst            (rst),
      .enable         (state_q == ST_DRAIN),
      .upstream_valid (bus.upstream_valid),
      .quiet          (quiet),
      .timeout        (timeout)
   );

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) state_d = (bus.commit_target == IDLE_CONFIG_ID) ? ST_RESUME : ST_DRAIN;
         end
         ST_DRAIN: begin
            if (quiet)        state_d = ST_PRIME;
            else if (timeout) state_d = ST_IDLE;
         end
         ST_PRIME: begin
            state_d = ST_STREAM;
            k_d     = '0;
         end
         ST_STREAM: begin
            if (k_q == ADDR_W'(MAX_CHAINS - 1)) begin
               state_d = ST_RESUME;
               k_d     = '0;
            end else begin
               k_d = k_q + ADDR_W'(1);
            end
         end
         ST_RESUME: state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // Outputs are decoded from the next state so they line up with the state register.
   always_comb begin
      tracing_d     = 1'b1;
      config_id_d   = IDLE_CONFIG_ID;
      config_data_d = FW_PASSTHROUGH;
      done_d        = 1'b0;
      busy_d        = (state_d != ST_IDLE);
      error_d       = 1'b0;
      case (state_d)
         ST_PRIME: tracing_d = 1'b0;
         ST_STREAM: begin
            tracing_d     = 1'b0;
            config_id_d   = target_q;
            config_data_d = snap[k_d];
         end
         ST_RESUME: done_d = 1'b1;
`ifdef REDUCE_FW_SEQ_TIMEOUT_EN
         ST_IDLE: error_d = (state_q == ST_DRAIN);
`endif
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= ST_IDLE;
         k_q            <= '0;
         bus.tracing    <= 1'b1;
         bus.configId   <= IDLE_CONFIG_ID;
         bus.configData <= FW_PASSTHROUGH;
         bus.busy       <= 1'b0;
         bus.done       <= 1'b0;
      end else begin
         state_q        <= state_d;
         k_q            <= k_d;
         bus.tracing    <= tracing_d;
         bus.configId   <= config_id_d;
         bus.configData <= config_data_d;
         bus.busy       <= busy_d;
         bus.done       <= done_d;
      end
   end

`ifdef REDUCE_FW_SEQ_TIMEOUT_EN
   always_ff @(posedge clk) begin
      if (rst) bus.error <= 1'b0;
      else     bus.error <= error_d;
   end
`else
   assign bus.error = 1'b0;
   logic unused_error_d;
   assign unused_error_d = error_d;
`endif

endmodule

// File: tb/tb_reduce_fw_sequencer.sv
// Self-checking bench for reduce_fw_sequencer; timeout scenario follows
// REDUCE_FW_SEQ_TIMEOUT_EN.
module tb_reduce_fw_sequencer;
   localparam int         M       = 4;
   localparam int         D       = 4;
   localparam int         TO      = 16;
   localparam logic [7:0] IDLE_ID = 8'hFF;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   reduce_fw_sequencer_if #(.MAX_CHAINS(M)) bus ();

   reduce_fw_sequencer #(
      .MAX_CHAINS     (M),
      .DRAIN_CYCLES   (D),
      .IDLE_CONFIG_ID (IDLE_ID),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   int         n_checks = 0;
   int         n_pass   = 0;
   logic [7:0] tbl_m [M];
   logic [7:0] exp_q [$];

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.tbl_we         = 1'b0;
      bus.tbl_addr       = '0;
      bus.tbl_data       = '0;
      bus.commit_valid   = 1'b0;
      bus.commit_target  = '0;
      bus.upstream_valid = 1'b0;
   endtask

   task automatic clear_model();
      for (int k = 0; k < M; k++) tbl_m[k] = 8'h00;
   endtask

   task automatic write_tbl(input int addr, input logic [7:0] data);
      bus.tbl_we   = 1'b1;
      bus.tbl_addr = 2'(addr);
      bus.tbl_data = data;
      tbl_m[addr]  = data;
      next_cycle();
      bus.tbl_we = 1'b0;
   endtask

   // One commit, cycle 0 = acceptance. Expected timeline comes from the drain rule:
   // PRIME follows the first run of D quiet cycles, then M stream beats, then done.
   task automatic run_commit(input string name, input logic [7:0] tgt, input logic [63:0] up_mask,
                             input int wr_cycle, input int wr_addr, input logic [7:0] wr_data);
      int p, fin, run;
      logic exp_tr, exp_done, exp_busy, exp_rdy, in_stream;
      logic [7:0] exp_id, exp_data;
      p = -100;
      if (tgt == IDLE_ID) begin
         fin = 1;
      end else begin
         run = 0;
         p   = -1;
         for (int i = 1; i < 60 && p < 0; i++) begin
            if (up_mask[i]) run = 0;
            else            run++;
            if (run == D) p = i + 1;
         end
         fin = p + M + 1;
      end
      exp_q.delete();
      for (int k = 0; k < M; k++)
         exp_q.push_back((wr_cycle == 0 && wr_addr == k) ? wr_data : tbl_m[k]);
      if (bus.commit_ready !== 1'b1) $display("FAIL %s ready_at_accept got %b want 1", name, bus.commit_ready);
      else n_pass++;
      n_checks++;
      for (int i = 0; i <= fin + 1; i++) begin
         if (i > 0) begin
            in_stream = (i >= p + 1) && (i <= p + M);
            exp_tr    = !(in_stream || i == p);
            exp_id    = in_stream ? tgt : IDLE_ID;
            exp_data  = 8'h00;
            if (in_stream) exp_data = exp_q.pop_front();
            exp_done  = (i == fin);
            exp_busy  = (i <= fin);
            exp_rdy   = (i > fin);
            if (bus.tracing !== exp_tr) $display("FAIL %s tracing c%0d got %b want %b", name, i, bus.tracing, exp_tr);
            else n_pass++;
            if (bus.configId !== exp_id) $display("FAIL %s configId c%0d got %h want %h", name, i, bus.configId, exp_id);
            else n_pass++;
            if (bus.configData !== exp_data) $display("FAIL %s configData c%0d got %h want %h", name, i, bus.configData, exp_data);
            else n_pass++;
            if (bus.done !== exp_done) $display("FAIL %s done c%0d got %b want %b", name, i, bus.done, exp_done);
            else n_pass++;
            if (bus.busy !== exp_busy) $display("FAIL %s busy c%0d got %b want %b", name, i, bus.busy, exp_busy);
            else n_pass++;
            if (bus.commit_ready !== exp_rdy) $display("FAIL %s commit_ready c%0d got %b want %b", name, i, bus.commit_ready, exp_rdy);
            else n_pass++;
            if (bus.error !== 1'b0) $display("FAIL %s error c%0d got %b want 0", name, i, bus.error);
            else n_pass++;
            n_checks += 7;
         end
         if (i <= fin) begin
            bus.commit_valid   = (i == 0);
            bus.commit_target  = tgt;
            bus.upstream_valid = up_mask[i];
            bus.tbl_we         = (i == wr_cycle);
            bus.tbl_addr       = 2'(wr_addr);
            bus.tbl_data       = wr_data;
            if (i == wr_cycle) tbl_m[wr_addr] = wr_data;
            next_cycle();
         end
      end
      idle_inputs();
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1'b1;
      repeat (3) next_cycle();
      if (bus.tracing !== 1'b1 || bus.configId !== IDLE_ID || bus.configData !== 8'h00)
         $display("FAIL reset_bus got %b/%h/%h want 1/ff/00", bus.tracing, bus.configId, bus.configData);
      else n_pass++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.error !== 1'b0)
         $display("FAIL reset_flags got %b%b%b want 000", bus.busy, bus.done, bus.error);
      else n_pass++;
      if (bus.commit_ready !== 1'b0) $display("FAIL reset_ready_in_rst got %b want 0", bus.commit_ready);
      else n_pass++;
      rst = 1'b0;
      #1;
      if (bus.commit_ready !== 1'b1) $display("FAIL reset_ready_after got %b want 1", bus.commit_ready);
      else n_pass++;
      n_checks += 4;
      clear_model();
   endtask

   task automatic test_basic();
      write_tbl(0, 8'd1);
      write_tbl(1, 8'd0);
      write_tbl(2, 8'd1);
      write_tbl(3, 8'd0);
      run_commit("basic", 8'd3, 64'd0, -1, 0, 8'd0);
   endtask

   task automatic test_drain_restart();
      run_commit("drain_restart", 8'd3, 64'h14, -1, 0, 8'd0);
   endtask

   task automatic test_back_to_back();
      write_tbl(2, 8'd0);
      run_commit("write_through", 8'd3, 64'd0, 0, 2, 8'd1);
      run_commit("write_in_stream", 8'd3, 64'd0, 7, 0, 8'h5A);
      run_commit("next_commit", 8'd3, 64'd0, -1, 0, 8'd0);
   endtask

   task automatic test_noop();
      run_commit("noop", IDLE_ID, 64'h6, -1, 0, 8'd0);
   endtask

   task automatic test_reset_mid_stream();
      write_tbl(1, 8'h33);
      bus.commit_valid  = 1'b1;
      bus.commit_target = 8'd5;
      next_cycle();
      idle_inputs();
      repeat (D + 2) next_cycle();
      if (bus.configId !== 8'd5 || bus.configData !== tbl_m[1])
         $display("FAIL rst_mid k1_beat got %h/%h want 05/%h", bus.configId, bus.configData, tbl_m[1]);
      else n_pass++;
      rst = 1'b1;
      next_cycle();
      if (bus.tracing !== 1'b1 || bus.configId !== IDLE_ID || bus.busy !== 1'b0 || bus.done !== 1'b0)
         $display("FAIL rst_mid after got %b/%h/%b/%b want 1/ff/0/0", bus.tracing, bus.configId, bus.busy, bus.done);
      else n_pass++;
      if (bus.commit_ready !== 1'b0) $display("FAIL rst_mid ready_in_rst got %b want 0", bus.commit_ready);
      else n_pass++;
      rst = 1'b0;
      #1;
      if (bus.commit_ready !== 1'b1) $display("FAIL rst_mid ready_release got %b want 1", bus.commit_ready);
      else n_pass++;
      n_checks += 4;
      clear_model();
      for (int i = 0; i < 4; i++) begin
         next_cycle();
         if (bus.done !== 1'b0 || bus.tracing !== 1'b1) $display("FAIL rst_mid quiet c%0d got %b/%b want 0/1", i, bus.done, bus.tracing);
         else n_pass++;
         n_checks++;
      end
   endtask

   task automatic test_timeout();
      int last;
      logic exp_err, exp_busy;
`ifdef REDUCE_FW_SEQ_TIMEOUT_EN
      last = TO + 3;
`else
      last = 40;
`endif
      bus.upstream_valid = 1'b1;
      bus.commit_valid   = 1'b1;
      bus.commit_target  = 8'd7;
      next_cycle();
      bus.commit_valid = 1'b0;
      for (int i = 1; i <= last; i++) begin
`ifdef REDUCE_FW_SEQ_TIMEOUT_EN
         exp_err  = (i == TO + 1);
         exp_busy = (i <= TO);
`else
         exp_err  = 1'b0;
         exp_busy = 1'b1;
`endif
         if (bus.error !== exp_err) $display("FAIL timeout error c%0d got %b want %b", i, bus.error, exp_err);
         else n_pass++;
         if (bus.busy !== exp_busy) $display("FAIL timeout busy c%0d got %b want %b", i, bus.busy, exp_busy);
         else n_pass++;
         if (bus.tracing !== 1'b1 || bus.configId !== IDLE_ID)
            $display("FAIL timeout bus c%0d got %b/%h want 1/ff", i, bus.tracing, bus.configId);
         else n_pass++;
         n_checks += 3;
         next_cycle();
      end
      idle_inputs();
      rst = 1'b1;
      next_cycle();
      rst = 1'b0;
      clear_model();
   endtask

   task automatic test_random();
      logic [63:0] mask;
      int          wc;
      for (int r = 0; r < 6; r++) begin
         for (int k = 0; k < M; k++) write_tbl(k, 8'($urandom_range(0, 255)));
         mask = '0;
         for (int i = 1; i <= 12; i++) mask[i] = ($urandom_range(0, 3) == 0);
         wc = $urandom_range(0, 3);
         run_commit("random", 8'($urandom_range(0, 254)), mask, wc,
                    $urandom_range(0, M - 1), 8'($urandom_range(0, 255)));
      end
   endtask

   initial begin
      rst = 1'b1;
      idle_inputs();
      clear_model();
      test_reset();
      test_basic();
      test_drain_restart();
      test_back_to_back();
      test_noop();
      test_reset_mid_stream();
      test_timeout();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
